// File: rtl/tl_uh_sram_responder.sv
// TileLink-UH responder in front of a single-port synchronous SRAM.
// One request in flight; Get bursts stream one beat per cycle on channel D.
module tl_uh_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MAX_SIZE    = 7
) (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_i,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [3:0]  a_size,
    input  logic [31:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    input  logic        a_corrupt,
    input  logic        a_valid,
    output logic        a_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [3:0]  d_size,
    output logic        d_denied,
    output logic [31:0] d_data,
    output logic        d_corrupt,
    output logic        d_valid,
    input  logic        d_ready
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam int          CW          = (MAX_SIZE > 2) ? int'(MAX_SIZE) - 2 : 1;
    localparam logic [33:0] RANGE_BYTES = 34'(DEPTH_WORDS) * 34'd4;
    localparam logic [3:0]  MAX_SIZE_L  = MAX_SIZE[3:0];

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_ACK,
        ERR
    } state_t;

    state_t state, state_next, a_class;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] cur_word;
    logic [AW-1:0] a_word;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_last;
    logic [CW-1:0] rd_last;
    logic [31:0]   offset;
    logic [31:0]   size_bytes;
    logic [31:0]   beat_span;
    logic [33:0]   end_byte;
    logic          is_get, is_put, aligned, in_range;
    logic          accept, d_hs, final_beat, mem_we, mem_re;
    logic          unused_ok;

    assign offset     = a_address - BASE_ADDR;
    assign size_bytes = 32'd1 << a_size;
    assign end_byte   = {2'b00, offset} + {2'b00, size_bytes};
    assign in_range   = (a_address >= BASE_ADDR) && (end_byte <= RANGE_BYTES);
    assign aligned    = (a_address & (size_bytes - 32'd1)) == 32'd0;
    assign is_get     = (a_opcode == 3'd4);
    assign is_put     = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign a_word     = offset[AW+1:2];
    assign beat_span  = (32'd1 << (a_size - 4'd2)) - 32'd1;
    assign rd_last    = (a_size > 4'd2) ? beat_span[CW-1:0] : '0;

    assign a_ready    = (state == IDLE) && !cpu_rst_i;
    assign accept     = a_valid && a_ready;
    assign d_hs       = d_valid && d_ready;
    assign final_beat = (beat_cnt == beat_last);
    assign d_param    = 2'b00;
    assign d_corrupt  = 1'b0;
    assign unused_ok  = ^{a_param, offset[31:AW+2], offset[1:0], beat_span[31:CW]};

    // Request classification; earlier checks take priority over later ones.
    always_comb begin
        a_class = ERR;
        if (!(is_get || is_put) || !aligned || !in_range)
            a_class = ERR;
        else if (is_get && (a_size > MAX_SIZE_L))
            a_class = ERR;
        else if (is_put && (a_size > 4'd2))
            a_class = ERR;
        else if (is_put && a_corrupt)
            a_class = ERR;
        else if (is_get)
            a_class = RD_BURST;
        else
            a_class = WR_ACK;
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = cur_word + AW'(1);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = a_class;
                    mem_addr   = a_word;
                    mem_we     = (a_class == WR_ACK);
                    mem_re     = (a_class == RD_BURST);
                end
            end
            RD_BURST: begin
                if (d_hs && final_beat)
                    state_next = IDLE;
                else if (d_hs)
                    mem_re = 1'b1;
            end
            WR_ACK, ERR: begin
                if (d_hs)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            state     <= IDLE;
            d_valid   <= 1'b0;
            d_opcode  <= 3'd0;
            d_size    <= 4'd0;
            d_denied  <= 1'b0;
            beat_cnt  <= '0;
            beat_last <= '0;
            cur_word  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                d_valid   <= 1'b1;
                d_opcode  <= is_get ? 3'd1 : 3'd0;
                d_size    <= a_size;
                d_denied  <= (a_class == ERR);
                beat_cnt  <= '0;
                beat_last <= (a_class == RD_BURST) ? rd_last : '0;
                cur_word  <= a_word;
            end else if (d_hs) begin
                if (final_beat) begin
                    d_valid <= 1'b0;
                end else begin
                    beat_cnt <= beat_cnt + CW'(1);
                    cur_word <= cur_word + AW'(1);
                end
            end
        end
    end

    // Read data only moves on a read strobe, so it holds under backpressure.
    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i)
            d_data <= 32'd0;
        else if (mem_re)
            d_data <= mem[mem_addr];
        else if (accept)
            d_data <= 32'd0;
    end

    always_ff @(posedge cpu_clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_mask[i])
                    mem[mem_addr][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_tl_uh_sram_responder.sv
// Testbench for tl_uh_sram_responder: table-driven single-beat vectors plus
// hand-written burst, backpressure and reset sequences, checked via a beat queue.
module tb_tl_uh_sram_responder;

    localparam int DEPTH = 4096;

    logic        cpu_clk_i = 1'b0;
    logic        cpu_rst_i;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        d_valid;
    logic        d_ready;

    tl_uh_sram_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (32'h0000_0000),
        .MAX_SIZE   (7)
    ) dut (
        .cpu_clk_i(cpu_clk_i),
        .cpu_rst_i(cpu_rst_i),
        .a_opcode (a_opcode),
        .a_param  (a_param),
        .a_size   (a_size),
        .a_address(a_address),
        .a_mask   (a_mask),
        .a_data   (a_data),
        .a_corrupt(a_corrupt),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .d_opcode (d_opcode),
        .d_param  (d_param),
        .d_size   (d_size),
        .d_denied (d_denied),
        .d_data   (d_data),
        .d_corrupt(d_corrupt),
        .d_valid  (d_valid),
        .d_ready  (d_ready)
    );

    always #5 cpu_clk_i = ~cpu_clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
        logic [2:0]  e_op;
        logic        e_den;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  size;
        logic        den;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    vec_t  vecs[13];
    int    n_vec = 0;
    int    n_mis = 0;
    int    cycles;
    int    n;

    function automatic logic [31:0] fill_word(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [2:0] op, input logic [3:0] size,
                             input logic den, input logic [31:0] data);
        beat_t b;
        b.op = op; b.size = size; b.den = den; b.data = data;
        exp_q.push_back(b);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] size,
                                 input logic [31:0] addr, input logic [3:0] mask,
                                 input logic [31:0] data, input logic corrupt);
        int k;
        a_opcode = op; a_size = size; a_address = addr;
        a_mask = mask; a_data = data; a_corrupt = corrupt; a_valid = 1'b1;
        k = 0;
        @(negedge cpu_clk_i);
        while (!a_ready && k < 100) begin
            @(negedge cpu_clk_i);
            k++;
        end
        if (!a_ready)
            check("a_accept_timeout", 64'(a_ready), 64'd1);
        @(posedge cpu_clk_i);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, output int cyc);
        logic [3:0] pat;
        pat = 4'b1001;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge cpu_clk_i);
            #1;
            cyc++;
            if (toggle)
                d_ready = pat[i[1:0]];
            if (exp_q.size() == 0)
                break;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        d_ready = 1'b1;
    endtask

    // Every visible beat, stalled or not, is compared against the queue head.
    always @(negedge cpu_clk_i) begin
        if (!cpu_rst_i && d_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(d_valid), 64'd0);
            end else begin
                mon_e = exp_q[0];
                check("checkOutput_d_beat",
                      {21'b0, d_opcode, d_param, d_size, d_denied, d_corrupt, d_data},
                      {21'b0, mon_e.op, 2'b00, mon_e.size, mon_e.den, 1'b0, mon_e.data});
                if (d_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        vecs[0]  = '{3'd0, 4'd2, 32'h10,   4'hF,    32'h1122_3344, 1'b0, 3'd0, 1'b0, 32'h0};
        vecs[1]  = '{3'd1, 4'd2, 32'h10,   4'b0101, 32'hAABB_CCDD, 1'b0, 3'd0, 1'b0, 32'h0};
        vecs[2]  = '{3'd4, 4'd2, 32'h10,   4'hF,    32'h0,         1'b0, 3'd1, 1'b0, 32'h11BB_33DD};
        vecs[3]  = '{3'd4, 4'd8, 32'h0,    4'hF,    32'h0,         1'b0, 3'd1, 1'b1, 32'h0};
        vecs[4]  = '{3'd4, 4'd2, 32'h82,   4'hF,    32'h0,         1'b0, 3'd1, 1'b1, 32'h0};
        vecs[5]  = '{3'd0, 4'd2, 32'h4000, 4'hF,    32'hDEAD_BEEF, 1'b0, 3'd0, 1'b1, 32'h0};
        vecs[6]  = '{3'd0, 4'd2, 32'h10,   4'hF,    32'hFFFF_FFFF, 1'b1, 3'd0, 1'b1, 32'h0};
        vecs[7]  = '{3'd4, 4'd2, 32'h10,   4'hF,    32'h0,         1'b0, 3'd1, 1'b0, 32'h11BB_33DD};
        vecs[8]  = '{3'd2, 4'd2, 32'h0,    4'hF,    32'h0,         1'b0, 3'd0, 1'b1, 32'h0};
        vecs[9]  = '{3'd0, 4'd3, 32'h8,    4'hF,    32'h0,         1'b0, 3'd0, 1'b1, 32'h0};
        vecs[10] = '{3'd4, 4'd1, 32'h1,    4'hF,    32'h0,         1'b0, 3'd1, 1'b1, 32'h0};
        vecs[11] = '{3'd4, 4'd1, 32'h2,    4'hF,    32'h0,         1'b0, 3'd1, 1'b0, fill_word(0)};
        vecs[12] = '{3'd4, 4'd0, 32'h3,    4'hF,    32'h0,         1'b0, 3'd1, 1'b0, fill_word(0)};

        cpu_rst_i = 1'b1;
        a_opcode = 3'd0; a_param = 3'd0; a_size = 4'd0; a_address = 32'd0;
        a_mask = 4'd0; a_data = 32'd0; a_corrupt = 1'b0; a_valid = 1'b0;
        d_ready = 1'b1;
        repeat (3) @(posedge cpu_clk_i);
        #1;
        check("reset_state", 64'({a_ready, d_valid, d_opcode, d_size, d_denied, d_data}), 64'd0);
        cpu_rst_i = 1'b0;
        @(posedge cpu_clk_i);
        #1;

        for (int i = 0; i < 64; i++) begin
            push_beat(3'd0, 4'd2, 1'b0, 32'd0);
            applyStimulus(3'd0, 4'd2, 32'(4 * i), 4'hF, fill_word(i), 1'b0);
            drain(1'b0, cycles);
        end

        for (int i = 0; i < 13; i++) begin
            push_beat(vecs[i].e_op, vecs[i].size, vecs[i].e_den, vecs[i].e_data);
            applyStimulus(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].mask,
                          vecs[i].data, vecs[i].corrupt);
            drain(1'b0, cycles);
        end

        // Full-line burst with no backpressure.
        for (int k = 0; k < 32; k++)
            push_beat(3'd1, 4'd7, 1'b0, fill_word(32 + k));
        applyStimulus(3'd4, 4'd7, 32'h80, 4'hF, 32'd0, 1'b0);
        drain(1'b0, cycles);
        check("burst_cycles", 64'(cycles), 64'd32);
        check("a_ready_after_burst", 64'(a_ready), 64'd1);
        check("d_valid_after_burst", 64'(d_valid), 64'd0);

        // Same burst under a 1,0,0,1 ready pattern.
        for (int k = 0; k < 32; k++)
            push_beat(3'd1, 4'd7, 1'b0, fill_word(32 + k));
        applyStimulus(3'd4, 4'd7, 32'h80, 4'hF, 32'd0, 1'b0);
        drain(1'b1, cycles);
        check("d_valid_after_stall_burst", 64'(d_valid), 64'd0);

        // Reset in the middle of a burst.
        for (int k = 0; k < 32; k++)
            push_beat(3'd1, 4'd7, 1'b0, fill_word(32 + k));
        applyStimulus(3'd4, 4'd7, 32'h80, 4'hF, 32'd0, 1'b0);
        n = 0;
        while (exp_q.size() > 26 && n < 100) begin
            @(posedge cpu_clk_i);
            #1;
            n++;
        end
        check("beats_before_reset", 64'(exp_q.size()), 64'd26);
        cpu_rst_i = 1'b1;
        exp_q.delete();
        @(posedge cpu_clk_i);
        #1;
        check("reset_mid_burst", 64'({d_valid, a_ready}), 64'd0);
        cpu_rst_i = 1'b0;
        #1;
        check("a_ready_after_reset", 64'(a_ready), 64'd1);
        push_beat(3'd1, 4'd2, 1'b0, fill_word(0));
        applyStimulus(3'd4, 4'd2, 32'h0, 4'hF, 32'd0, 1'b0);
        drain(1'b0, cycles);

        repeat (3) @(posedge cpu_clk_i);
        #1;
        check("idle_at_end", 64'({d_valid, a_ready}), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/tl_uh_sram_responder.md
Name: tl_uh_sram_responder

Overview:
- TileLink-UH slave (responder) backed by single-port synchronous SRAM; serves instruction/data fetch masters such as the frontend I-cache.
- Accepts Get (burst reads up to 128-byte lines), PutFullData and PutPartialData (single-beat writes); returns AccessAckData/AccessAck on channel D at one beat per cycle.
- Sits on the memory side of the fetch interconnect, opposite the cache's A/D master ports.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit SRAM words (power of two).
- BASE_ADDR, 32'h0000_0000: byte base address; valid range is [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
- MAX_SIZE, 7: largest accepted Get size as log2 bytes (7 = 128 B = 32 beats).

Ports:
- cpu_clk_i in 1: clock; all logic on rising edge.
- cpu_rst_i in 1: synchronous active-high reset.
- a_opcode in 3: 0 PutFull, 1 PutPartial, 4 Get; others unsupported.
- a_param in 3: ignored.
- a_size in 4: log2 transfer bytes.
- a_address in 32: byte address.
- a_mask in 4: byte-lane write enables.
- a_data in 32: write data.
- a_corrupt in 1: if set on a Put, the write is suppressed and the response is denied.
- a_valid in 1 / a_ready out 1: A handshake.
- d_opcode out 3: 0 AccessAck, 1 AccessAckData.
- d_param out 2: always 0.
- d_size out 4: echoes accepted a_size.
- d_denied out 1: error response.
- d_data out 32: read beat data.
- d_corrupt out 1: always 0.
- d_valid out 1 / d_ready in 1: D handshake.

Behaviour:
- Reset: state IDLE, d_valid=0, d_opcode=0, d_size=0, d_denied=0, d_data=0, beat counter=0. a_ready=0 while cpu_rst_i is high. SRAM contents are not cleared.
- a_ready = (state==IDLE) & !cpu_rst_i. There is one outstanding request; no A acceptance while a response is in flight.
- Acceptance occurs on a_valid & a_ready at edge T. Command fields are latched, and the first SRAM read or write happens at that edge. d_valid rises at T+1 (latency 1).
- Classification at acceptance, in priority order:
  1. Unsupported opcode, misaligned address (a_address mod 2^size != 0), or any byte outside range → ERR.
  2. Get with size > MAX_SIZE → ERR.
  3. Put with size > 2 → ERR.
  4. Get → RD_BURST.
  5. Put → WR_ACK.
- States:
  - IDLE: waits for acceptance.
  - RD_BURST: beats = 1 if size<=2, else 2^size/4. d_opcode=1, d_denied=0. Beat k carries word (a_address>>2)+k; word addresses increment linearly with no wrap inside a burst. On d_valid & d_ready, the next word is read at the same edge, so back-to-back beats are possible with no bubbles. When the final beat is accepted → IDLE, d_valid=0 next cycle, a_ready=1.
  - WR_ACK: SRAM is written at the acceptance edge. A byte lane is written only if a_mask[i] is set; for PutFull the mask is used as given. Response is one beat, d_opcode=0, d_data=0. On handshake → IDLE.
  - ERR: Get → one beat, opcode 1. Others → one beat, opcode 0. denied=1, data=0, no SRAM access. On handshake → IDLE.
- Backpressure: while d_valid & !d_ready, all D outputs hold stable and the SRAM read enable is low, so read data holds.
- Sub-word Get (size 0/1) returns the full aligned word; the master selects bytes.
- Reset mid-burst: the burst is abandoned, d_valid=0 from the next cycle, and no further beats are sent. Any partially written state stays as already written.
- Simultaneous events:
  - A cycle with a final-beat handshake has a_ready=0, so a new request waits one cycle.
  - A handshake on the final beat together with cpu_rst_i: reset wins.

Test Plan:
- Get, addr 0x80, size 7, d_ready=1 constant. Expect: d_valid from T+1 for 32 consecutive cycles; beat k data = mem[32+k]; d_size=7, opcode 1; a_ready returns 1 the cycle after beat 31.
- Same Get with d_ready toggled 1,0,0,1. Expect: d_data constant across stall cycles; no beat skipped or duplicated; total 32 beats.
- PutPartial, addr 0x10, mask 4'b0101, data 0xAABBCCDD, over old value 0x11223344. Expect: AccessAck opcode 0, denied 0; a following Get size 2 returns 0x11BB33DD.
- Get size 8. Then Get addr 0x82 size 2. Then Put addr 4*DEPTH_WORDS size 2. Expect: each produces a single beat with d_denied=1, d_data=0; opcodes 1, 1, 0 respectively; memory unchanged.
- Get size 7, reset asserted after beat 5. Expect: d_valid=0 the cycle after reset; a_ready=1 once reset drops; a new Get size 2 of addr 0 returns mem[0].
- Get size 0 at addr 0x3. Expect: one beat containing the full word mem[0], d_size=0.
